// File: rtl/a2d_scan_intf.sv
// Round-robin A/D scanner: drives an SPI A/D converter through NUM_CH mapped channels,
// optionally averaging 2^AVG_LOG2 samples per slot, started by nxt or a free-running interval timer.
module a2d_scan_intf #(
   parameter int unsigned             NUM_CH   = 4,
   parameter logic [NUM_CH*3-1:0]     CH_MAP   = {3'd6, 3'd5, 3'd4, 3'd0},
   parameter int unsigned             AVG_LOG2 = 0,
   parameter int unsigned             INTERVAL = 50000,
   localparam int unsigned            SLOT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   nxt,
   input  logic                   auto_en,
   output logic [NUM_CH*12-1:0]   result,
   output logic [NUM_CH-1:0]      valid,
   output logic                   busy,
   output logic                   cnv_done,
   output logic [SLOT_W-1:0]      cnv_slot,
   input  logic                   MISO,
   output logic                   SCLK,
   output logic                   MOSI,
   output logic                   SS_n
);

   localparam int unsigned   ACC_W   = 12 + AVG_LOG2;
   localparam int unsigned   CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned   TMR_W   = $clog2(INTERVAL);
   localparam logic [CNT_W-1:0] N_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMR_W-1:0] TMR_RLD = TMR_W'(INTERVAL - 1);

   typedef enum logic [2:0] {IDLE, CMD, GAP, READ, REPT} state_t;

   state_t                 r_state, w_nxt_state;
   logic [SLOT_W-1:0]      r_slot;
   logic [CNT_W-1:0]       r_cnt;
   logic [ACC_W-1:0]       r_acc;
   logic [TMR_W-1:0]       r_tmr;
   logic [NUM_CH*12-1:0]   r_result;
   logic [NUM_CH-1:0]      r_valid;
   logic                   r_upd;
   logic                   r_cnv_done;
   logic [SLOT_W-1:0]      r_cnv_slot;

   logic [4:0]             r_div;
   logic [4:0]             r_bitcnt;
   logic [15:0]            r_shft;
   logic                   r_miso;
   logic                   r_xfer;
   logic                   r_ss_n;
   logic                   r_done;

   logic                   w_tick;
   logic                   w_start;
   logic                   w_wrt;
   logic                   w_upd_set;
   logic                   w_last;
   logic [2:0]             w_ch;
   logic [15:0]            w_wt_data;
   logic [ACC_W-1:0]       w_sum;
   logic [11:0]            w_avg;

   assign w_tick    = auto_en && (r_tmr == '0);
   assign w_start   = (r_state == IDLE) && !r_upd && (nxt || w_tick);
   assign w_last    = (r_cnt == N_LAST);
   assign w_wt_data = {2'b00, w_ch, 11'h000};
   assign w_sum     = r_acc + ACC_W'(r_shft[11:0]);
   assign w_avg     = r_acc[AVG_LOG2 +: 12];

   always_comb begin
      w_ch = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_slot == SLOT_W'(i)) w_ch = CH_MAP[3*i +: 3];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_wrt       = 1'b0;
      w_upd_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_wrt       = 1'b1;
               w_nxt_state = CMD;
            end
         end
         CMD:  if (r_done) w_nxt_state = GAP;
         GAP: begin
            w_wrt       = 1'b1;
            w_nxt_state = READ;
         end
         READ: begin
            if (r_done) begin
               if (w_last) begin
                  w_upd_set   = 1'b1;
                  w_nxt_state = IDLE;
               end else begin
                  w_nxt_state = REPT;
               end
            end
         end
         REPT: begin
            w_wrt       = 1'b1;
            w_nxt_state = CMD;
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Accumulate on each read; the upd cycle commits the average and advances the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot     <= '0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_tmr      <= '0;
         r_result   <= '0;
         r_valid    <= '0;
         r_upd      <= 1'b0;
         r_cnv_done <= 1'b0;
         r_cnv_slot <= '0;
      end else begin
         if (!auto_en)          r_tmr <= TMR_RLD;
         else if (r_tmr == '0)  r_tmr <= TMR_RLD;
         else                   r_tmr <= r_tmr - TMR_W'(1);

         r_upd      <= w_upd_set;
         r_cnv_done <= r_upd;

         if ((r_state == READ) && r_done) begin
            r_acc <= w_sum;
            if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
         end

         if (r_upd) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (r_slot == SLOT_W'(i)) begin
                  r_result[12*i +: 12] <= w_avg;
                  r_valid[i]           <= 1'b1;
               end
            end
            r_acc      <= '0;
            r_cnt      <= '0;
            r_cnv_slot <= r_slot;
            if (r_slot == SLOT_W'(NUM_CH - 1)) r_slot <= '0;
            else                               r_slot <= r_slot + SLOT_W'(1);
         end
      end
   end

   // SPI master: SCLK = clk/32, idles high; MISO sampled on SCLK rise, MOSI shifted on fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xfer   <= 1'b0;
         r_ss_n   <= 1'b1;
         r_done   <= 1'b0;
         r_div    <= 5'h10;
         r_bitcnt <= 5'd0;
         r_shft   <= 16'h0000;
         r_miso   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_wrt) begin
            r_xfer   <= 1'b1;
            r_ss_n   <= 1'b0;
            r_div    <= 5'h00;
            r_bitcnt <= 5'd0;
            r_shft   <= w_wt_data;
         end else if (r_xfer) begin
            if ((r_bitcnt == 5'd16) && (r_div == 5'h1E)) begin
               r_xfer <= 1'b0;
               r_ss_n <= 1'b1;
               r_done <= 1'b1;
               r_div  <= 5'h10;
               r_shft <= {r_shft[14:0], r_miso};
            end else begin
               r_div <= r_div + 5'd1;
               if (r_div == 5'h0F) begin
                  r_miso   <= MISO;
                  r_bitcnt <= r_bitcnt + 5'd1;
               end
               if (r_div == 5'h1F) r_shft <= {r_shft[14:0], r_miso};
            end
         end
      end
   end

   assign SCLK     = r_div[4];
   assign MOSI     = r_shft[15];
   assign SS_n     = r_ss_n;
   assign result   = r_result;
   assign valid    = r_valid;
   assign busy     = (r_state != IDLE) || r_upd;
   assign cnv_done = r_cnv_done;
   assign cnv_slot = r_cnv_slot;

endmodule
